vga_fb_arbiter: RTL

//  Shares one single-port framebuffer RAM between VGA scan-out and a pixel writer, and runs a fill engine.

---
 rtl/vga_fb_arbiter_if.sv | 22 ++
 rtl/vga_fb_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Pixel-writer channel into the framebuffer arbiter: valid/ready handshake
// carrying one pixel coordinate and its RGB444 colour.
interface vga_fb_arbiter_if #(
    parameter int XBITS = 10,
    parameter int YBITS = 10
);
    logic             wr_valid;
    logic             wr_ready;
    logic [XBITS-1:0] wr_x;
    logic [YBITS-1:0] wr_y;
    logic [11:0]      wr_color;

    modport master (
        output wr_valid, wr_x, wr_y, wr_color,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_color,
        output wr_ready
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: one scan-out read per 4 visible pixels,
// every other RAM cycle goes to the fill engine or the pixel writer.
module vga_fb_arbiter #(
    parameter int XBITS = 10,
    parameter int YBITS = 10,
    parameter int HRES  = 640,
    parameter int VRES  = 480,
    parameter int WPL   = 160,
    parameter int AW    = 17
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [XBITS-1:0] x,
    input  logic [YBITS-1:0] y,
    input  logic             activevideo,
    input  logic             hsync_in,
    input  logic             vsync_in,
    vga_fb_arbiter_if.slave  wr,
    input  logic             fill_start,
    input  logic [11:0]      fill_color,
    output logic             fill_busy,
    output logic             fill_done,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_we,
    output logic [3:0]       mem_wmask,
    output logic [47:0]      mem_wdata,
    input  logic [47:0]      mem_rdata,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue,
    output logic             hsync,
    output logic             vsync,
    output logic             avideo
);

    localparam logic [AW-1:0]    LAST_WORD = AW'(WPL * VRES - 1);
    localparam logic [XBITS-1:0] HRES_X    = XBITS'(HRES);
    localparam logic [YBITS-1:0] VRES_Y    = YBITS'(VRES);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] fill_cnt, fill_cnt_nx;
    logic [11:0]   fill_rgb;
    logic          fill_done_nx;

    logic          disp_slot;
    logic          wr_in_range;
    logic [AW-1:0] disp_addr;
    logic [AW-1:0] wr_addr;

    // Scan-out pipeline
    logic          rd_pend;
    logic [47:0]   pix_sr;
    logic [1:0]    hs_d, vs_d, av_d;

    assign disp_slot   = activevideo & (x[1:0] == 2'b00);
    assign wr_in_range = (wr.wr_x < HRES_X) & (wr.wr_y < VRES_Y);
    assign disp_addr   = AW'(y) * AW'(WPL) + AW'(x[XBITS-1:2]);
    assign wr_addr     = AW'(wr.wr_y) * AW'(WPL) + AW'(wr.wr_x[XBITS-1:2]);

    assign wr.wr_ready = (state == IDLE) & ~disp_slot;
    assign fill_busy   = (state == FILL);

    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave a value held and infer a latch.
    always_comb begin
        state_nx     = state;
        fill_cnt_nx  = fill_cnt;
        fill_done_nx = 1'b0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wmask    = 4'h0;
        mem_wdata    = '0;

        if (disp_slot) begin
            mem_addr = disp_addr;
        end else if (state == FILL) begin
            mem_addr  = fill_cnt;
            mem_we    = 1'b1;
            mem_wmask = 4'hF;
            mem_wdata = {4{fill_rgb}};
            if (fill_cnt == LAST_WORD) begin
                state_nx     = IDLE;
                fill_cnt_nx  = '0;
                fill_done_nx = 1'b1;
            end else begin
                fill_cnt_nx = fill_cnt + AW'(1);
            end
        end else if (wr.wr_valid & wr_in_range) begin
            mem_addr  = wr_addr;
            mem_we    = 1'b1;
            mem_wmask = 4'b0001 << wr.wr_x[1:0];
            mem_wdata = {4{wr.wr_color}};
        end

        if (state == IDLE && fill_start) begin
            state_nx    = FILL;
            fill_cnt_nx = '0;
        end

        // RAM stays untouched while reset is held, including a fill cut short.
        mem_we = mem_we & reset_n;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            fill_done <= 1'b0;
            fill_rgb  <= '0;
        end else begin
            state     <= state_nx;
            fill_cnt  <= fill_cnt_nx;
            fill_done <= fill_done_nx;
            if (state == IDLE && fill_start) begin
                fill_rgb <= fill_color;
            end
        end
    end

    // Read data lands one cycle after the address; load it into the shift
    // register then, so lane 0 shows two cycles after its timer cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_pend <= 1'b0;
            pix_sr  <= '0;
            hs_d    <= 2'b11;
            vs_d    <= 2'b11;
            av_d    <= 2'b00;
        end else begin
            rd_pend <= disp_slot;
            pix_sr  <= rd_pend ? mem_rdata : {12'h000, pix_sr[47:12]};
            hs_d    <= {hs_d[0], hsync_in};
            vs_d    <= {vs_d[0], vsync_in};
            av_d    <= {av_d[0], activevideo};
        end
    end

    assign hsync  = hs_d[1];
    assign vsync  = vs_d[1];
    assign avideo = av_d[1];
    assign {red, green, blue} = av_d[1] ? pix_sr[11:0] : 12'h000;

endmodule
